ldm_stm_sequencer: RTL
======================

LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst (asserted low).
REQ-002 Parameters SHALL be: WORD_BYTES, default 4, address stride per register; REG_PC, default 15, index of the PC.
REQ-003 Ports SHALL be as follows, clock and reset first:
- clk  in  1  clock.
- rst  in  1  async active-low reset.
- start  in  1  begin a transfer; sampled in IDLE only.
- is_load  in  1  1=LDM, 0=STM.
- pre  in  1  pre-index (P bit).
- up  in  1  ascending (U bit).
- writeback  in  1  base writeback (W bit).
- base_reg  in  4  base register index.
- base_val  in  32  base register value.
- reg_list  in  16  register list.
- mem_ready  in  1  memory accepts/returns this cycle.
- mem_rdata  in  32  load data.
- r_data_c  in  32  register-file read port C data.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request.
- mem_we  out  1  store enable.
- mem_addr  out  32  word address.
- mem_wdata  out  32  store data.
- r_addr_c  out  4  register-file read port C address.
- w_addr  out  4  register-file write address.
- w_data  out  32  register-file write data.
- write_reg  out  1  register-file write strobe.
- write_pc  out  1  PC write strobe.
- pc_data  out  32  PC write data.

Function
REQ-004 The FSM SHALL have states IDLE, SETUP, XFER, WB and DONE.
REQ-005 In IDLE with start=1, the block SHALL latch all command inputs and enter SETUP; start SHALL be ignored in every other state.
REQ-006 In SETUP (one cycle), the block SHALL compute n=popcount(reg_list) and the start address (width-truncated to 32 bits):
- IA: base.
- IB: base+4.
- DA: base-4n+4.
- DB: base-4n.
REQ-007 If n=0, SETUP SHALL go directly to DONE with no memory access and no writeback.
REQ-008 In XFER, registers SHALL be processed in ascending index order; the address SHALL increment by WORD_BYTES per register.
REQ-009 In XFER, mem_req SHALL be held high with stable mem_addr/mem_we/mem_wdata until mem_req&mem_ready (the handshake); the next register SHALL start the following cycle.
REQ-010 For STM, r_addr_c SHALL equal the current register index (combinational), and mem_wdata SHALL equal r_data_c.
REQ-011 For LDM, in the handshake cycle the block SHALL drive write_reg=1, w_addr=reg, w_data=mem_rdata.
REQ-012 For LDM of REG_PC, the block SHALL instead drive write_pc=1 with pc_data=mem_rdata and write_reg=0.
REQ-013 After the last handshake, the block SHALL go to WB if writeback=1, else to DONE.
REQ-014 WB SHALL last one cycle and drive write_reg=1, w_addr=base_reg, w_data = up ? base+4n : base-4n.
REQ-015 WB SHALL suppress write_reg when is_load=1 and base_reg is in the list (the loaded value wins).
REQ-016 DONE SHALL pulse done=1 for one cycle, then return to IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 write_reg and write_pc SHALL never both be 1 in the same cycle.

Reset
REQ-019 rst low SHALL immediately force IDLE and drive all outputs to 0, including mid-transfer; no partial writeback SHALL occur.
REQ-020 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-021 FSM state encodings, WORD_BYTES and REG_PC SHALL live in the shared defines package used by the register-file blocks.
REQ-022 One sub-module SHALL exist: lowest_set_bit, which returns the index of the lowest set bit of the 16-bit remaining-list mask plus a valid flag.
REQ-023 The remaining-list mask SHALL clear the current bit on each handshake; there SHALL be no loop-based scan in the sequential logic.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- LDMIA base=0x100, list=0x000E, W=1, mem_ready always 1 -> R1..R3 written from 0x100/0x104/0x108; R[base]=0x10C; done at cycle 6 after start.
- STMDB base=0x200, list=0x8003 -> r_addr_c sequence 0,1,15; mem_addr 0x1F4/0x1F8/0x1FC; mem_we=1 each handshake.
- LDMIB list=0x8000, mem_ready stalled 3 cycles -> mem_addr=base+4 held stable for the stall; write_pc=1 once; write_reg never asserted.
- LDMIA W=1, base_reg=2, list=0x0004 -> R2 = loaded value; no WB write.
- list=0x0000 -> done 2 cycles after start; mem_req never asserted.
- rst low during the 2nd of 4 transfers -> all outputs 0 immediately; a new start after release completes normally.

Source files
------------

// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared defines for the LDM/STM sequencer and the register-file side blocks:
// FSM encodings, transfer geometry and the latched command record.
package ldm_stm_sequencer_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned REG_PC     = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_WB    = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic        is_load;
    logic        pre;
    logic        up;
    logic        writeback;
    logic [3:0]  base_reg;
    logic [31:0] base_val;
    logic [15:0] reg_list;
  } seq_cmd_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of the remaining register mask.
module lowest_set_bit (
  input  logic [15:0] mask_i,
  output logic [3:0]  idx_o,
  output logic        valid_o
);

  always_comb begin
    idx_o = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask_i[i]) idx_o = 4'(i);
    end
  end

  assign valid_o = |mask_i;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Block-transfer sequencer: walks a 16-bit register list against memory for
// load-multiple / store-multiple, with optional base writeback.
//   state | meaning
//   IDLE  | waiting for start, command latched on start
//   SETUP | popcount and first address computed
//   XFER  | one register per memory handshake, lowest index first
//   WB    | base register update (skipped write if loaded by LDM)
//   DONE  | one-cycle completion pulse
module ldm_stm_sequencer #(
  parameter int unsigned WORD_BYTES = ldm_stm_sequencer_pkg::WORD_BYTES,
  parameter int unsigned REG_PC     = ldm_stm_sequencer_pkg::REG_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        pre,
  input  logic        up,
  input  logic        writeback,
  input  logic [3:0]  base_reg,
  input  logic [31:0] base_val,
  input  logic [15:0] reg_list,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] r_data_c,
  output logic        busy,
  output logic        done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  r_addr_c,
  output logic [3:0]  w_addr,
  output logic [31:0] w_data,
  output logic        write_reg,
  output logic        write_pc,
  output logic [31:0] pc_data
);

  import ldm_stm_sequencer_pkg::*;

  localparam logic [31:0] STRIDE = 32'(WORD_BYTES);
  localparam logic [3:0]  PC_IDX = 4'(REG_PC);

  seq_state_e  state_q, state_d;
  seq_cmd_t    cmd_q, cmd_d;
  logic [15:0] remaining_q, remaining_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] span_q, span_d;

  logic [3:0]  cur_idx;
  logic        cur_valid;
  logic [4:0]  n_setup;
  logic [31:0] span_setup;

  lowest_set_bit u_lsb (
    .mask_i  (remaining_q),
    .idx_o   (cur_idx),
    .valid_o (cur_valid)
  );

  assign n_setup    = popcount16(cmd_q.reg_list);
  assign span_setup = STRIDE * {27'd0, n_setup};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      span_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      span_q      <= span_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    span_d      = span_q;

    busy      = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    r_addr_c  = '0;
    w_addr    = '0;
    w_data    = '0;
    write_reg = 1'b0;
    write_pc  = 1'b0;
    pc_data   = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cmd_d.is_load   = is_load;
          cmd_d.pre       = pre;
          cmd_d.up        = up;
          cmd_d.writeback = writeback;
          cmd_d.base_reg  = base_reg;
          cmd_d.base_val  = base_val;
          cmd_d.reg_list  = reg_list;
          remaining_d     = reg_list;
          state_d         = ST_SETUP;
        end
      end

      ST_SETUP: begin
        busy   = 1'b1;
        span_d = span_setup;
        // Lowest address of the block; registers always fill upward from it.
        case ({cmd_q.pre, cmd_q.up})
          2'b01:   addr_d = cmd_q.base_val;
          2'b11:   addr_d = cmd_q.base_val + STRIDE;
          2'b00:   addr_d = cmd_q.base_val - span_setup + STRIDE;
          default: addr_d = cmd_q.base_val - span_setup;
        endcase
        state_d = (n_setup == 5'd0) ? ST_DONE : ST_XFER;
      end

      ST_XFER: begin
        busy     = 1'b1;
        mem_req  = cur_valid;
        mem_addr = addr_q;
        mem_we   = ~cmd_q.is_load;
        if (!cmd_q.is_load) begin
          r_addr_c  = cur_idx;
          mem_wdata = r_data_c;
        end
        if (!cur_valid) begin
          state_d = cmd_q.writeback ? ST_WB : ST_DONE;
        end else if (mem_ready) begin
          if (cmd_q.is_load) begin
            if (cur_idx == PC_IDX) begin
              write_pc = 1'b1;
              pc_data  = mem_rdata;
            end else begin
              write_reg = 1'b1;
              w_addr    = cur_idx;
              w_data    = mem_rdata;
            end
          end
          remaining_d = remaining_q & ~(16'd1 << cur_idx);
          addr_d      = addr_q + STRIDE;
          if (remaining_d == 16'd0) begin
            state_d = cmd_q.writeback ? ST_WB : ST_DONE;
          end
        end
      end

      ST_WB: begin
        busy = 1'b1;
        // A base register reloaded by LDM keeps the loaded value.
        if (!(cmd_q.is_load && cmd_q.reg_list[cmd_q.base_reg])) begin
          write_reg = 1'b1;
          w_addr    = cmd_q.base_reg;
          w_data    = cmd_q.up ? (cmd_q.base_val + span_q) : (cmd_q.base_val - span_q);
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
